rr_grant_arbiter: RTL and testbench

//   Round-robin arbiter: shares one resource (output queue, register bus, DMA

---
 rtl/rr_grant_arbiter_pkg.sv | 11 +
 rtl/rr_grant_arbiter_priority_encoder.sv | 33 +++
 rtl/rr_grant_arbiter.sv | 155 +++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM state encoding.
package rr_grant_arbiter_pkg;

    // The arbiter is either waiting for a request or holding a grant until the
    // owner signals done.
    typedef enum logic {
        ARB_STATE_IDLE = 1'b0,
        ARB_STATE_BUSY = 1'b1
    } arb_state_e;

endpackage : rr_grant_arbiter_pkg

// File: rtl/rr_grant_arbiter_priority_encoder.sv
// Priority encoder: reports the index of the winning set bit of req_in.
// Bit order is [0:INPUT_WIDTH-1], so with RIGHT_TO_LEFT_PRIORITY=0 the
// leftmost bit (index 0) has the highest priority.
module priority_encoder #(
    parameter int INPUT_WIDTH            = 8,
    parameter int OUTPUT_WIDTH           = 3,
    parameter bit RIGHT_TO_LEFT_PRIORITY = 1'b0
) (
    input  logic [0:INPUT_WIDTH-1]  req_in,
    output logic [OUTPUT_WIDTH-1:0] idx_out,
    output logic                    vld_out
);

    // Scan so that the highest-priority set bit is the last one written.
    always_comb begin
        idx_out = '0;
        vld_out = |req_in;
        if (RIGHT_TO_LEFT_PRIORITY) begin
            for (int i = 0; i < INPUT_WIDTH; i++) begin
                if (req_in[i]) begin
                    idx_out = OUTPUT_WIDTH'(i);
                end
            end
        end else begin
            for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
                if (req_in[i]) begin
                    idx_out = OUTPUT_WIDTH'(i);
                end
            end
        end
    end

endmodule : priority_encoder

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter sharing one resource among 2**NUM_REQ_WIDTH requesters.
// A grant is held until its owner pulses done; the next owner is chosen
// starting just above the previous owner and wrapping around.
module rr_grant_arbiter #(
    parameter  int NUM_REQ_WIDTH = 3,
    localparam int NUM_REQ       = 1 << NUM_REQ_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     done,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ_WIDTH-1:0] grant_idx,
    output logic                     grant_vld
);

    import rr_grant_arbiter_pkg::*;

    arb_state_e               state_q;
    arb_state_e               state_d;
    logic [NUM_REQ-1:0]       grant_q;
    logic [NUM_REQ-1:0]       grant_d;
    logic [NUM_REQ_WIDTH-1:0] grant_idx_q;
    logic [NUM_REQ_WIDTH-1:0] grant_idx_d;
    logic                     grant_vld_q;
    logic                     grant_vld_d;
    logic [NUM_REQ_WIDTH-1:0] last_idx_q;
    logic [NUM_REQ_WIDTH-1:0] last_idx_d;

    logic [NUM_REQ-1:0]       mask;
    logic [NUM_REQ-1:0]       masked_req;
    logic [0:NUM_REQ-1]       masked_enc_in;
    logic [0:NUM_REQ-1]       unmasked_enc_in;
    logic [NUM_REQ_WIDTH-1:0] masked_pick;
    logic [NUM_REQ_WIDTH-1:0] unmasked_pick;
    logic [NUM_REQ_WIDTH-1:0] pick_idx;
    logic                     masked_any;
    logic                     any_req;
    logic                     load_grant;
    logic                     release_grant;

    // Only requesters above the previous owner are eligible in the first pass.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (NUM_REQ_WIDTH'(i) > last_idx_q);
        end
        masked_req = req & mask;
    end

    // The encoders number their inputs left to right, so requester i is
    // routed explicitly to encoder bit i.
    always_comb begin
        masked_enc_in   = '0;
        unmasked_enc_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked_enc_in[i]   = masked_req[i];
            unmasked_enc_in[i] = req[i];
        end
    end

    priority_encoder #(
        .INPUT_WIDTH            (NUM_REQ),
        .OUTPUT_WIDTH           (NUM_REQ_WIDTH),
        .RIGHT_TO_LEFT_PRIORITY (1'b0)
    ) u_masked_enc (
        .req_in  (masked_enc_in),
        .idx_out (masked_pick),
        .vld_out (masked_any)
    );

    priority_encoder #(
        .INPUT_WIDTH            (NUM_REQ),
        .OUTPUT_WIDTH           (NUM_REQ_WIDTH),
        .RIGHT_TO_LEFT_PRIORITY (1'b0)
    ) u_unmasked_enc (
        .req_in  (unmasked_enc_in),
        .idx_out (unmasked_pick),
        .vld_out (any_req)
    );

    // Prefer a requester above the last owner; otherwise wrap to the lowest one.
    always_comb begin
        pick_idx = masked_any ? masked_pick : unmasked_pick;
    end

    // State and grant registers; reset drops the outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_STATE_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            last_idx_q  <= '1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            grant_vld_q <= grant_vld_d;
            last_idx_q  <= last_idx_d;
        end
    end

    // Next state: grant on any request when idle; on done either hand over
    // directly to the next requester or fall back to idle.
    always_comb begin
        state_d       = state_q;
        load_grant    = 1'b0;
        release_grant = 1'b0;
        case (state_q)
            ARB_STATE_IDLE: begin
                if (any_req) begin
                    state_d    = ARB_STATE_BUSY;
                    load_grant = 1'b1;
                end
            end
            ARB_STATE_BUSY: begin
                if (done) begin
                    if (any_req) begin
                        load_grant = 1'b1;
                    end else begin
                        release_grant = 1'b1;
                        state_d       = ARB_STATE_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_STATE_IDLE;
            end
        endcase
    end

    // Outputs: load the picked owner, clear on release, otherwise hold.
    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        grant_vld_d = grant_vld_q;
        last_idx_d  = last_idx_q;
        if (load_grant) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            grant_idx_d       = pick_idx;
            grant_vld_d       = 1'b1;
            last_idx_d        = pick_idx;
        end else if (release_grant) begin
            grant_d     = '0;
            grant_vld_d = 1'b0;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign grant_vld = grant_vld_q;

endmodule : rr_grant_arbiter

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: an 8-requester instance and a
// 2-requester instance, checked against hand-computed expectations.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;

    logic [1:0] req1;
    logic       done1;
    logic [1:0] grant1;
    logic [0:0] grant_idx1;
    logic       grant_vld1;

    int vectors;
    int miscompares;

    rr_grant_arbiter #(.NUM_REQ_WIDTH(3)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    rr_grant_arbiter #(.NUM_REQ_WIDTH(1)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req1),
        .done      (done1),
        .grant     (grant1),
        .grant_idx (grant_idx1),
        .grant_vld (grant_vld1)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkGrant8(input string tag, input logic [7:0] g,
                               input logic [2:0] idx, input logic vld);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
        checkOutput({tag, ".idx"},   32'(grant_idx), 32'(idx));
        checkOutput({tag, ".vld"},   32'(grant_vld), 32'(vld));
    endtask

    task automatic checkGrant2(input string tag, input logic [1:0] g,
                               input logic [0:0] idx, input logic vld);
        checkOutput({tag, ".grant"}, 32'(grant1), 32'(g));
        checkOutput({tag, ".idx"},   32'(grant_idx1), 32'(idx));
        checkOutput({tag, ".vld"},   32'(grant_vld1), 32'(vld));
    endtask

    initial begin
        logic [2:0] exp_idx;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req1        = 2'b00;
        done1       = 1'b0;
        applyStimulus(8'h00, 1'b0);
        #3;
        checkGrant8("reset", 8'h00, 3'd0, 1'b0);
        #9;
        reset = 1'b0;
        step();
        checkGrant8("idle_after_reset", 8'h00, 3'd0, 1'b0);

        // Single request: granted one clock later.
        $display("[TB] single request");
        applyStimulus(8'h01, 1'b0);
        step();
        checkGrant8("t1_grant0", 8'h01, 3'd0, 1'b1);

        // All requesting with done every cycle: rotate 1..7 then wrap to 0.
        $display("[TB] full rotation");
        applyStimulus(8'hFF, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            exp_idx = 3'(k % 8);
            step();
            checkGrant8($sformatf("t2_rot%0d", k), 8'h01 << exp_idx, exp_idx, 1'b1);
        end

        // Wrap-around: from owner 5, requests on 2 and 5 go to 2, then 5.
        $display("[TB] wrap-around");
        applyStimulus(8'h20, 1'b1);
        step();
        checkGrant8("t3_grant5", 8'h20, 3'd5, 1'b1);
        applyStimulus(8'h24, 1'b1);
        step();
        checkGrant8("t3_wrap2", 8'h04, 3'd2, 1'b1);
        step();
        checkGrant8("t3_back5", 8'h20, 3'd5, 1'b1);

        // Hold while done is low even with requests withdrawn, then release.
        $display("[TB] hold and release");
        applyStimulus(8'h08, 1'b1);
        step();
        checkGrant8("t4_grant3", 8'h08, 3'd3, 1'b1);
        applyStimulus(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkGrant8($sformatf("t4_hold%0d", k), 8'h08, 3'd3, 1'b1);
        end
        applyStimulus(8'h00, 1'b1);
        step();
        checkGrant8("t4_release", 8'h00, 3'd3, 1'b0);
        step();
        checkGrant8("t4_idle_done", 8'h00, 3'd3, 1'b0);

        // From idle, priority resumes above the last owner (3): bits 0,4 -> 4.
        applyStimulus(8'h11, 1'b1);
        step();
        checkGrant8("t4_resume4", 8'h10, 3'd4, 1'b1);

        // Asynchronous reset mid-grant, away from the clock edge.
        $display("[TB] async reset");
        applyStimulus(8'h81, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkGrant8("t5_async_reset", 8'h00, 3'd0, 1'b0);
        step();
        #3;
        reset = 1'b0;
        step();
        checkGrant8("t5_after_reset", 8'h01, 3'd0, 1'b1);
        applyStimulus(8'h81, 1'b1);
        step();
        checkGrant8("t5_next7", 8'h80, 3'd7, 1'b1);

        // Sole requester finishing with its request still high is re-granted.
        applyStimulus(8'h80, 1'b1);
        step();
        checkGrant8("t5_sole_regrant", 8'h80, 3'd7, 1'b1);
        applyStimulus(8'h00, 1'b0);

        // Two-requester instance alternates 0,1,0,1.
        $display("[TB] two-requester alternation");
        checkGrant2("t6_idle", 2'b00, 1'b0, 1'b0);
        req1  = 2'b11;
        done1 = 1'b0;
        step();
        checkGrant2("t6_first0", 2'b01, 1'b0, 1'b1);
        done1 = 1'b1;
        step();
        checkGrant2("t6_alt1", 2'b10, 1'b1, 1'b1);
        step();
        checkGrant2("t6_alt0", 2'b01, 1'b0, 1'b1);
        step();
        checkGrant2("t6_alt1b", 2'b10, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rr_grant_arbiter
